// File: rtl/bubble_sort_ctrl_pkg.sv
// Shared definitions for the bubble sort controller: FSM encoding and a width helper.
package bubble_sort_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCompare = 2'd1,
    StSwap    = 2'd2,
    StDone    = 2'd3
  } state_e;

  // Ceiling log2, at least 1 so a counter always has a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/dp_sub.sv
// Plain unsigned subtractor; the caller zero-extends so the MSB acts as the borrow.
module dp_sub #(
  parameter int unsigned datawidth = 9
) (
  input  logic [datawidth-1:0] a_i,
  input  logic [datawidth-1:0] b_i,
  output logic [datawidth-1:0] diff_o
);

  assign diff_o = a_i - b_i;

endmodule

// File: rtl/bubble_sort_ctrl.sv
// In-place unsigned bubble sort sequencer over a small register bank with host load/read.
module bubble_sort_ctrl
  import bubble_sort_ctrl_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned NUM_ELEM  = 4,
  parameter int unsigned ADDRWIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_en,
  input  logic [ADDRWIDTH-1:0] load_addr,
  input  logic [DATAWIDTH-1:0] load_data,
  input  logic                 start,
  input  logic [ADDRWIDTH-1:0] rd_addr,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 busy,
  output logic                 done
);

  // Pass count never exceeds NUM_ELEM-2, so clog2(NUM_ELEM) bits suffice.
  localparam int unsigned PassW = clog2(NUM_ELEM);

  state_e                 state_q;
  logic [DATAWIDTH-1:0]   elem_q [NUM_ELEM];
  logic [ADDRWIDTH-1:0]   i_q;
  logic [PassW-1:0]       pass_q;
  logic                   swapped_q;
  logic                   busy_q;
  logic                   done_q;

  logic [DATAWIDTH-1:0]   a_val;
  logic [DATAWIDTH-1:0]   b_val;
  logic [DATAWIDTH:0]     diff;
  logic                   swap_cond;
  logic                   last_cmp;
  logic                   last_pass;
  logic                   swapped_eff;

  // Select the adjacent pair elem[i], elem[i+1] for the comparator.
  always_comb begin
    a_val = '0;
    b_val = '0;
    for (int unsigned k = 0; k < NUM_ELEM; k++) begin
      if (32'(i_q) == k)         a_val = elem_q[k];
      if (32'(i_q) + 32'd1 == k) b_val = elem_q[k];
    end
  end

  dp_sub #(
    .datawidth(DATAWIDTH + 1)
  ) u_dp_sub (
    .a_i   ({1'b0, a_val}),
    .b_i   ({1'b0, b_val}),
    .diff_o(diff)
  );

  // No borrow and non-zero difference means elem[i] > elem[i+1]; equal never swaps.
  always_comb begin
    swap_cond   = !diff[DATAWIDTH] && (diff != '0);
    last_cmp    = !((32'(i_q) + 32'(pass_q)) < (NUM_ELEM - 32'd2));
    last_pass   = (32'(pass_q) == (NUM_ELEM - 32'd2));
    swapped_eff = swapped_q || (state_q == StSwap);
  end

  // Combinational readback; out-of-range addresses read as zero.
  always_comb begin
    rd_data = '0;
    for (int unsigned k = 0; k < NUM_ELEM; k++) begin
      if (32'(rd_addr) == k) rd_data = elem_q[k];
    end
  end

  // Sequencer FSM together with the element bank, counters and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      i_q       <= '0;
      pass_q    <= '0;
      swapped_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int unsigned k = 0; k < NUM_ELEM; k++) elem_q[k] <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          for (int unsigned k = 0; k < NUM_ELEM; k++) begin
            if (load_en && (32'(load_addr) == k)) elem_q[k] <= load_data;
          end
          if (start) begin
            state_q   <= StCompare;
            i_q       <= '0;
            pass_q    <= '0;
            swapped_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StCompare, StSwap: begin
          if ((state_q == StCompare) && swap_cond) begin
            state_q <= StSwap;
          end else begin
            if (state_q == StSwap) begin
              for (int unsigned k = 0; k < NUM_ELEM; k++) begin
                if (32'(i_q) == k)         elem_q[k] <= b_val;
                if (32'(i_q) + 32'd1 == k) elem_q[k] <= a_val;
              end
              swapped_q <= 1'b1;
            end
            // Advance: next pair, finish, or start the next pass.
            if (!last_cmp) begin
              i_q     <= i_q + ADDRWIDTH'(1);
              state_q <= StCompare;
            end else if (!swapped_eff || last_pass) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pass_q    <= pass_q + PassW'(1);
              i_q       <= '0;
              swapped_q <= 1'b0;
              state_q   <= StCompare;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule
